// File: rtl/div_result_display.sv
// Multiplexed 4-digit hex display for the divider result: captures each valid result and
// scans it onto a common-anode 7-segment display, one digit slot per REFRESH_CYCLES clocks.
module div_result_display #(
  parameter int unsigned REFRESH_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        result_valid,
  input  logic [15:0] result,
  input  logic        mode,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        new_result
);

  localparam int unsigned CntW = $clog2(REFRESH_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_CYCLES - 1);

  typedef enum logic {StEmpty, StShow} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [15:0]     result_q, result_d;
  logic            mode_q, mode_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;
  logic            dp_q, dp_d;
  logic            new_result_q, new_result_d;

  logic            cnt_wrap;
  logic            blank;
  logic [3:0]      nibble;
  logic [6:0]      hex_seg;

  always_comb begin
    unique case (idx_q)
      2'd0:    nibble = result_q[3:0];
      2'd1:    nibble = result_q[7:4];
      2'd2:    nibble = result_q[11:8];
      default: nibble = result_q[15:12];
    endcase
  end

  // Segment order is {g,f,e,d,c,b,a}, active-low.
  always_comb begin
    unique case (nibble)
      4'h0:    hex_seg = 7'b1000000;
      4'h1:    hex_seg = 7'b1111001;
      4'h2:    hex_seg = 7'b0100100;
      4'h3:    hex_seg = 7'b0110000;
      4'h4:    hex_seg = 7'b0011001;
      4'h5:    hex_seg = 7'b0010010;
      4'h6:    hex_seg = 7'b0000010;
      4'h7:    hex_seg = 7'b1111000;
      4'h8:    hex_seg = 7'b0000000;
      4'h9:    hex_seg = 7'b0010000;
      4'hA:    hex_seg = 7'b0001000;
      4'hB:    hex_seg = 7'b0000011;
      4'hC:    hex_seg = 7'b1000110;
      4'hD:    hex_seg = 7'b0100001;
      4'hE:    hex_seg = 7'b0000110;
      default: hex_seg = 7'b0001110;
    endcase
  end

  always_comb begin
    cnt_wrap     = (cnt_q == CntMax);
    blank        = (cnt_q == '0);
    cnt_d        = cnt_wrap ? '0 : cnt_q + CntW'(1);
    idx_d        = cnt_wrap ? idx_q + 2'd1 : idx_q;
    result_d     = result_valid ? result : result_q;
    mode_d       = result_valid ? mode : mode_q;
    state_d      = result_valid ? StShow : state_q;
    new_result_d = result_valid;

    // Outputs are decoded from the pre-edge state, giving one cycle of latency.
    if (blank) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
      dp_d  = 1'b1;
    end else begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = (state_q == StShow) ? hex_seg : 7'b0111111;
      dp_d  = ~((state_q == StShow) && mode_q && (idx_q == 2'd0));
    end

    if (reset) begin
      cnt_d        = '0;
      idx_d        = 2'd0;
      result_d     = 16'h0000;
      mode_d       = 1'b0;
      state_d      = StEmpty;
      new_result_d = 1'b0;
      an_d         = 4'b1111;
      seg_d        = 7'b1111111;
      dp_d         = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    state_q      <= state_d;
    cnt_q        <= cnt_d;
    idx_q        <= idx_d;
    result_q     <= result_d;
    mode_q       <= mode_d;
    an_q         <= an_d;
    seg_q        <= seg_d;
    dp_q         <= dp_d;
    new_result_q <= new_result_d;
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign new_result = new_result_q;

endmodule

// File: tb/tb_div_result_display.sv
// Bench for div_result_display: a time-based display model checked every cycle, plus directed
// literal checks and a randomized capture/reset phase.
module tb_div_result_display;

  localparam int unsigned R = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        result_valid = 1'b0;
  logic [15:0] result = 16'h0000;
  logic        mode = 1'b0;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        new_result;

  int checks = 0;
  int errors = 0;

  div_result_display #(.REFRESH_CYCLES(R)) dut (
    .clk          (clk),
    .reset        (reset),
    .result_valid (result_valid),
    .result       (result),
    .mode         (mode),
    .an           (an),
    .seg          (seg),
    .dp           (dp),
    .new_result   (new_result)
  );

  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model: time since reset release determines slot position; a flag tracks "anything shown".
  int          m_cyc = 0;
  bit          m_shown = 0;
  logic [15:0] m_val = 16'h0;
  bit          m_mode = 0;
  bit          m_ok = 0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic        e_nr;

  always @(posedge clk) begin
    int cnt;
    int idx;
    if (reset) begin
      e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1; e_nr = 1'b0;
      m_cyc = 0; m_shown = 0; m_val = 16'h0; m_mode = 0;
      m_ok = 1;
    end else begin
      cnt = m_cyc % R;
      idx = (m_cyc / R) % 4;
      if (cnt == 0) begin
        e_an = 4'b1111; e_seg = 7'b1111111; e_dp = 1'b1;
      end else begin
        e_an = 4'b1111;
        e_an[idx] = 1'b0;
        e_seg = m_shown ? hex_tab[(m_val >> (4 * idx)) & 16'hF] : 7'b0111111;
        e_dp = !(m_shown && m_mode && idx == 0);
      end
      e_nr = result_valid;
      m_cyc++;
      if (result_valid) begin
        m_val = result; m_mode = mode; m_shown = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      checks++;
      if ({an, seg, dp, new_result} !== {e_an, e_seg, e_dp, e_nr}) begin
        errors++;
        $display("FAIL model_cmp t=%0t got an=%b seg=%b dp=%b nr=%b want an=%b seg=%b dp=%b nr=%b",
                 $time, an, seg, dp, new_result, e_an, e_seg, e_dp, e_nr);
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // Wait (bounded) for digit d to be lit, then compare its segments and dp to literals.
  task automatic check_digit(input int d, input logic [6:0] s, input logic p, input string name);
    logic [3:0] want_an;
    int n;
    want_an = 4'b1111;
    want_an[d] = 1'b0;
    n = 0;
    @(negedge clk);
    while (an !== want_an && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_an"}, {12'h0, an}, {12'h0, want_an});
    chk({name, "_seg"}, {9'h0, seg}, {9'h0, s});
    chk({name, "_dp"}, {15'h0, dp}, {15'h0, p});
  endtask

  task automatic pulse(input logic [15:0] v, input logic m);
    result = v; mode = m; result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  logic [3:0] scan_seq [16] = '{
    4'b1111, 4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1101, 4'b1101, 4'b1101,
    4'b1111, 4'b1011, 4'b1011, 4'b1011, 4'b1111, 4'b0111, 4'b0111, 4'b0111
  };

  initial begin
    int n;
    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_out", {an, seg, dp, new_result, 3'b0}, {4'b1111, 7'b1111111, 1'b1, 1'b0, 3'b0});
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("scan_an", {12'h0, an}, {12'h0, scan_seq[i]});
      if (scan_seq[i] != 4'b1111) chk("dash_seg", {9'h0, seg}, {9'h0, 7'b0111111});
    end

    pulse(16'h1A08, 1'b0);
    chk("nr_1a08", {15'h0, new_result}, 16'h1);
    check_digit(0, 7'b0000000, 1'b1, "d0_1a08");
    check_digit(1, 7'b1000000, 1'b1, "d1_1a08");
    check_digit(2, 7'b0001000, 1'b1, "d2_1a08");
    check_digit(3, 7'b1111001, 1'b1, "d3_1a08");

    pulse(16'h000F, 1'b1);
    check_digit(0, 7'b0001110, 1'b0, "d0_000f");
    check_digit(1, 7'b1000000, 1'b1, "d1_000f");
    check_digit(3, 7'b1000000, 1'b1, "d3_000f");

    result = 16'h1111; mode = 1'b0; result_valid = 1'b1;
    @(negedge clk);
    chk("nr_b2b_0", {15'h0, new_result}, 16'h1);
    result = 16'h2222;
    @(negedge clk);
    chk("nr_b2b_1", {15'h0, new_result}, 16'h1);
    result_valid = 1'b0;
    for (int d = 0; d < 4; d++) check_digit(d, 7'b0100100, 1'b1, "d_2222");

    // Reset while digit 2 is being shown.
    n = 0;
    while (an !== 4'b1011 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("reach_d2", {12'h0, an}, {12'h0, 4'b1011});
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_an", {12'h0, an}, {12'h0, 4'b1111});
    chk("mid_rst_seg", {9'h0, seg}, {9'h0, 7'b1111111});
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_blank", {12'h0, an}, {12'h0, 4'b1111});
    @(negedge clk);
    chk("post_rst_d0", {an, seg, dp, 4'b0}, {4'b1110, 7'b0111111, 1'b1, 4'b0});

    // Randomized captures with occasional resets; the model checks every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 199) == 0);
      result_valid = ($urandom_range(0, 7) == 0);
      result = 16'($urandom);
      mode = 1'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; result_valid = 1'b0;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
